// File: rtl/exc_pkg.sv
// Shared definitions for the exception/mode controller: state encoding,
// cause codes and mode constants.
package exc_pkg;

    typedef enum logic [1:0] {
        ST_USER   = 2'd0,
        ST_ENTER  = 2'd1,
        ST_SUPER  = 2'd2,
        ST_RETURN = 2'd3
    } exc_state_t;

    localparam logic [3:0] CAUSE_NONE     = 4'd0;
    localparam logic [3:0] CAUSE_TRAP     = 4'd1;
    localparam logic [3:0] CAUSE_IRQ_BASE = 4'd2;

    localparam logic MODE_USER  = 1'b1;
    localparam logic MODE_SUPER = 1'b0;

    // Cause code for interrupt line idx: 2 + idx.
    function automatic logic [3:0] irq_cause(input logic [2:0] idx);
        return CAUSE_IRQ_BASE + {1'b0, idx};
    endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Combinational lowest-index priority encoder: irq -> {valid, index}.
// Bit 0 is the highest priority.
module irq_prio_enc #(
    parameter int NUM_IRQ = 4
) (
    input  logic [NUM_IRQ-1:0] irq,
    output logic               valid,
    output logic [2:0]         index
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        valid = |irq;
        index = 3'd0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (irq[i]) index = 3'(i);
        end
    end

endmodule

// File: rtl/exc_ctrl.sv
// Exception/mode controller. Arbitrates traps against interrupts while in
// user mode, pulses exception entry and return (each exactly one cycle,
// with pipeline flush and PC redirect), and tracks user/supervisor mode.
// No nesting: requests are ignored while in the supervisor handler.
// Optional macro EXC_COUNT_EN: enables the 16-bit exceptions-taken counter;
// when undefined exc_count is tied to zero.
// dbg_state exposes the FSM state for observation.
module exc_ctrl
    import exc_pkg::*;
#(
    parameter int          NUM_IRQ     = 4,
    parameter logic [31:0] VECTOR_ADDR = 32'h0000_0080
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic               trap_in,
    input  logic               rfe_in,
    input  logic               stall_in,
    input  logic [31:0]        iar_in,
    output logic               exception,
    output logic               s_u,
    output logic               trap,
    output logic               flush,
    output logic               pc_sel,
    output logic [31:0]        pc_target,
    output logic [3:0]         cause,
    output logic [15:0]        exc_count,
    output exc_state_t         dbg_state
);

    exc_state_t state;
    logic       irq_valid;
    logic [2:0] irq_idx;

    irq_prio_enc #(.NUM_IRQ(NUM_IRQ)) u_prio (
        .irq   (irq),
        .valid (irq_valid),
        .index (irq_idx)
    );

    assign dbg_state = state;

    // Mode FSM with registered outputs: the pulse outputs are set on the edge
    // entering ENTER/RETURN so they are visible exactly during that cycle.
    // An irq still held after RETURN is only sampled at the end of the first
    // USER cycle, which guarantees one user instruction of forward progress.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_SUPER;
            s_u       <= MODE_SUPER;
            exception <= 1'b0;
            trap      <= 1'b0;
            flush     <= 1'b0;
            pc_sel    <= 1'b0;
            pc_target <= 32'h0;
            cause     <= CAUSE_NONE;
        end else begin
            exception <= 1'b0;
            trap      <= 1'b0;
            flush     <= 1'b0;
            pc_sel    <= 1'b0;
            case (state)
                ST_USER: begin
                    // rfe_in is a NOP here; trap_in wins over irq.
                    if (!stall_in && (trap_in || irq_valid)) begin
                        state     <= ST_ENTER;
                        s_u       <= MODE_SUPER;
                        exception <= 1'b1;
                        flush     <= 1'b1;
                        pc_sel    <= 1'b1;
                        pc_target <= VECTOR_ADDR;
                        if (trap_in) begin
                            cause <= CAUSE_TRAP;
                            trap  <= 1'b1;
                        end else begin
                            cause <= irq_cause(irq_idx);
                        end
                    end
                end
                ST_ENTER: begin
                    state <= ST_SUPER;
                end
                ST_SUPER: begin
                    if (rfe_in && !stall_in) begin
                        state     <= ST_RETURN;
                        flush     <= 1'b1;
                        pc_sel    <= 1'b1;
                        pc_target <= iar_in;
                        cause     <= CAUSE_NONE;
                    end
                end
                ST_RETURN: begin
                    state <= ST_USER;
                    s_u   <= MODE_USER;
                end
                default: begin
                    state <= ST_SUPER;
                end
            endcase
        end
    end

`ifdef EXC_COUNT_EN
    // Count every ENTER cycle; wraps naturally at 16 bits.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            exc_count <= 16'h0000;
        end else if (state == ST_ENTER) begin
            exc_count <= exc_count + 16'd1;
        end
    end
`else
    assign exc_count = 16'h0000;
`endif

endmodule

// File: tb/tb_exc_ctrl.sv
// Directed bench for exc_ctrl: an output-level reference model checked on
// every cycle, plus hand-computed literal checks from the test plan.
module tb_exc_ctrl;
    import exc_pkg::*;

    localparam int NUM_IRQ = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic [NUM_IRQ-1:0] irq = '0;
    logic        trap_in = 1'b0, rfe_in = 1'b0, stall_in = 1'b0;
    logic [31:0] iar_in = 32'h0;
    logic        exception, s_u, trap, flush, pc_sel;
    logic [31:0] pc_target;
    logic [3:0]  cause;
    logic [15:0] exc_count;
    exc_state_t  dbg_state;

    exc_ctrl #(.NUM_IRQ(NUM_IRQ), .VECTOR_ADDR(32'h0000_0080)) dut (
        .clk(clk), .reset(reset), .irq(irq), .trap_in(trap_in),
        .rfe_in(rfe_in), .stall_in(stall_in), .iar_in(iar_in),
        .exception(exception), .s_u(s_u), .trap(trap), .flush(flush),
        .pc_sel(pc_sel), .pc_target(pc_target), .cause(cause),
        .exc_count(exc_count), .dbg_state(dbg_state)
    );

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Tracks the observable outputs: an entry pulse is followed by the
    // handler, a return pulse is followed by user mode.
    logic        m_su = 0, m_exc = 0, m_trap = 0, m_flush = 0, m_pcsel = 0;
    logic [31:0] m_pct = 0;
    logic [3:0]  m_cause = 0;
    logic [15:0] m_cnt = 0;
    logic        was_entry, was_return;
    int          low;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_su = 0; m_exc = 0; m_trap = 0; m_flush = 0; m_pcsel = 0;
            m_pct = 0; m_cause = 0; m_cnt = 0;
        end else begin
            was_entry  = m_exc;
            was_return = m_flush && !m_exc;
            m_exc = 0; m_trap = 0; m_flush = 0; m_pcsel = 0;
            if (was_entry) begin
`ifdef EXC_COUNT_EN
                m_cnt = m_cnt + 16'd1;
`endif
            end else if (was_return) begin
                m_su = 1;
            end else if (m_su) begin
                if (!stall_in && (trap_in || irq != 0)) begin
                    m_exc = 1; m_su = 0; m_flush = 1; m_pcsel = 1;
                    m_pct = 32'h0000_0080;
                    if (trap_in) begin
                        m_cause = 4'd1; m_trap = 1;
                    end else begin
                        low = -1;
                        for (int i = 0; i < NUM_IRQ; i++)
                            if (low < 0 && irq[i]) low = i;
                        m_cause = 4'(2 + low);
                    end
                end
            end else if (rfe_in && !stall_in) begin
                m_flush = 1; m_pcsel = 1; m_pct = iar_in; m_cause = 0;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        chk("cyc_exception", {31'b0, exception}, {31'b0, m_exc});
        chk("cyc_s_u",       {31'b0, s_u},       {31'b0, m_su});
        chk("cyc_trap",      {31'b0, trap},      {31'b0, m_trap});
        chk("cyc_flush",     {31'b0, flush},     {31'b0, m_flush});
        chk("cyc_pc_sel",    {31'b0, pc_sel},    {31'b0, m_pcsel});
        chk("cyc_pc_target", pc_target,          m_pct);
        chk("cyc_cause",     {28'b0, cause},     {28'b0, m_cause});
        chk("cyc_exc_count", {16'b0, exc_count}, {16'b0, m_cnt});
    end

    // ---------------- driver ----------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_return();
        rfe_in = 1; tick(); rfe_in = 0;
        chk("ret_flush", {31'b0, flush}, 32'd1);
        tick();
        chk("ret_user", {31'b0, s_u}, 32'd1);
    endtask

    logic [15:0] exp_cnt;

    initial begin
        tick(); tick();
        chk("rst_s_u", {31'b0, s_u}, 32'd0);
        chk("rst_state", {30'b0, dbg_state}, {30'b0, ST_SUPER});
        chk("rst_pc_target", pc_target, 32'h0);
        chk("rst_exc_count", {16'b0, exc_count}, 32'h0);
        reset = 1;
        tick(); tick();
        chk("idle_super", {31'b0, s_u}, 32'd0);

        // First return into user mode.
        iar_in = 32'h0001_0000; rfe_in = 1; tick(); rfe_in = 0;
        chk("ret1_flush", {31'b0, flush}, 32'd1);
        chk("ret1_pc_sel", {31'b0, pc_sel}, 32'd1);
        chk("ret1_pc_target", pc_target, 32'h0001_0000);
        chk("ret1_s_u_low", {31'b0, s_u}, 32'd0);
        tick();
        chk("ret1_s_u_high", {31'b0, s_u}, 32'd1);
        chk("ret1_cause", {28'b0, cause}, 32'd0);
        chk("ret1_flush_off", {31'b0, flush}, 32'd0);

        // Interrupt entry, lowest set bit wins.
        irq = 4'b0110; tick(); irq = 0;
        chk("irq_exception", {31'b0, exception}, 32'd1);
        chk("irq_cause", {28'b0, cause}, 32'd3);
        chk("irq_vector", pc_target, 32'h0000_0080);
        chk("irq_trap", {31'b0, trap}, 32'd0);
        chk("irq_s_u", {31'b0, s_u}, 32'd0);
        tick();
        chk("irq_pulse_end", {31'b0, exception}, 32'd0);
        chk("irq_cause_held", {28'b0, cause}, 32'd3);
        do_return();

        // Trap beats irq in the same cycle.
        trap_in = 1; irq = 4'b0001; tick(); trap_in = 0; irq = 0;
        chk("trap_cause", {28'b0, cause}, 32'd1);
        chk("trap_flag", {31'b0, trap}, 32'd1);
        tick();
        chk("trap_flag_end", {31'b0, trap}, 32'd0);

        // No nesting in the handler; held irq taken after one user cycle.
        irq = 4'b1111;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("super_no_nest", {31'b0, exception}, 32'd0);
        end
        rfe_in = 1; tick(); rfe_in = 0;
        chk("held_ret_flush", {31'b0, flush}, 32'd1);
        tick();
        chk("held_user_cycle", {31'b0, exception}, 32'd0);
        chk("held_user_mode", {31'b0, s_u}, 32'd1);
        tick(); irq = 0;
        chk("held_entry", {31'b0, exception}, 32'd1);
        chk("held_cause", {28'b0, cause}, 32'd2);
        tick();
        do_return();

        // Stall holds off a trap in user mode.
        stall_in = 1; trap_in = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_no_entry", {31'b0, exception}, 32'd0);
        end
        stall_in = 0; tick(); trap_in = 0;
        chk("unstall_entry", {31'b0, exception}, 32'd1);
        tick();
`ifdef EXC_COUNT_EN
        exp_cnt = 16'd4;
`else
        exp_cnt = 16'd0;
`endif
        chk("count_after_4", {16'b0, exc_count}, {16'b0, exp_cnt});

        // Stall delays the return in supervisor mode.
        stall_in = 1; rfe_in = 1; tick(); tick();
        chk("stall_no_return", {31'b0, flush}, 32'd0);
        stall_in = 0; tick(); rfe_in = 0;
        chk("unstall_return", {31'b0, flush}, 32'd1);
        tick();

        // rfe in user mode is ignored.
        rfe_in = 1; tick(); rfe_in = 0;
        chk("user_rfe_nop", {31'b0, flush}, 32'd0);
        chk("user_rfe_mode", {31'b0, s_u}, 32'd1);

        // Reset in the middle of ENTER.
        trap_in = 1; tick(); trap_in = 0;
        chk("pre_reset_entry", {31'b0, exception}, 32'd1);
        #2 reset = 0;
        #1;
        chk("midrst_exception", {31'b0, exception}, 32'd0);
        chk("midrst_flush", {31'b0, flush}, 32'd0);
        chk("midrst_pc_target", pc_target, 32'h0);
        chk("midrst_cause", {28'b0, cause}, 32'd0);
        chk("midrst_count", {16'b0, exc_count}, 32'd0);
        tick(); reset = 1;
        tick();
        chk("post_rst_state", {30'b0, dbg_state}, {30'b0, ST_SUPER});

        // One more round trip after reset.
        do_return();
        irq = 4'b1000; tick(); irq = 0;
        chk("irq3_cause", {28'b0, cause}, 32'd5);
        tick();
`ifdef EXC_COUNT_EN
        exp_cnt = 16'd1;
`else
        exp_cnt = 16'd0;
`endif
        chk("count_after_rst", {16'b0, exc_count}, {16'b0, exp_cnt});
        tick(); tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Time limit so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, expected test end");
        $fatal(1, "watchdog");
    end

endmodule
